// File: rtl/td4_exec_core_if.sv
// Bundle between td4_exec_core and its bench-side ROM/board model.
// The master drives control, switches and ROM data. The slave (core) drives the ROM address and status.
interface td4_exec_core_if #(
  parameter int CNT_W = 8
);
  logic             run_en;
  logic             step;
  logic [3:0]       in_port;
  logic [3:0]       opecode;
  logic [3:0]       imm;
  logic [3:0]       addr;
  logic [3:0]       out_port;
  logic             carry;
  logic [CNT_W-1:0] retired;

  modport master (
    output run_en, step, in_port, opecode, imm,
    input  addr, out_port, carry, retired
  );

  modport slave (
    input  run_en, step, in_port, opecode, imm,
    output addr, out_port, carry, retired
  );
endinterface

// File: rtl/td4_exec_core.sv
// TD4-style 4-bit execution core: one instruction per enabled clock, fetched combinationally from ROM.
// Adds run/single-step gating and a wrapping retired-instruction counter.
module td4_exec_core #(
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  td4_exec_core_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [3:0]       pc_q, pc_d;
  logic [3:0]       out_q, out_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             step_q;
  logic             exe;
  logic [4:0]       sum_a, sum_b;

  assign sum_a = {1'b0, a_q} + {1'b0, bus.imm};
  assign sum_b = {1'b0, b_q} + {1'b0, bus.imm};

  // A step level held high only counts once, and in run mode it adds nothing.
  assign exe = bus.run_en | (bus.step & ~step_q);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    pc_d  = pc_q;
    out_d = out_q;
    c_d   = c_q;
    ret_d = ret_q;
    if (exe) begin
      c_d   = 1'b0;
      pc_d  = pc_q + 4'd1;
      ret_d = ret_q + CNT_ONE;
      case (bus.opecode)
        4'b0000: begin a_d = sum_a[3:0]; c_d = sum_a[4]; end
        4'b0001: a_d = b_q;
        4'b0010: a_d = bus.in_port;
        4'b0011: a_d = bus.imm;
        4'b0100: b_d = a_q;
        4'b0101: begin b_d = sum_b[3:0]; c_d = sum_b[4]; end
        4'b0110: b_d = bus.in_port;
        4'b0111: b_d = bus.imm;
        4'b1001: out_d = b_q;
        4'b1011: out_d = bus.imm;
        4'b1110: if (!c_q) pc_d = bus.imm;
        4'b1111: pc_d = bus.imm;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      pc_q   <= 4'd0;
      out_q  <= 4'd0;
      c_q    <= 1'b0;
      ret_q  <= '0;
      step_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      pc_q   <= pc_d;
      out_q  <= out_d;
      c_q    <= c_d;
      ret_q  <= ret_d;
      step_q <= bus.step;
    end
  end

  assign bus.addr     = pc_q;
  assign bus.out_port = out_q;
  assign bus.carry    = c_q;
  assign bus.retired  = ret_q;

endmodule

// File: tb/tb_td4_exec_core.sv
// Directed bench for td4_exec_core: a trace table for the counter program plus hand sequences
// for carry clearing, single-step, PC wrap and counter wrap.
module tb_td4_exec_core;

  logic       clk;
  logic       rst_n;
  logic       run_en;
  logic       step;
  logic [3:0] in_port;
  logic [3:0] rom_op  [16];
  logic [3:0] rom_imm [16];

  int n_cmp = 0;
  int n_bad = 0;

  td4_exec_core_if #(.CNT_W(8)) bus8 ();
  td4_exec_core_if #(.CNT_W(4)) bus4 ();

  assign bus8.run_en  = run_en;
  assign bus8.step    = step;
  assign bus8.in_port = in_port;
  assign bus8.opecode = rom_op[bus8.addr];
  assign bus8.imm     = rom_imm[bus8.addr];
  assign bus4.run_en  = run_en;
  assign bus4.step    = step;
  assign bus4.in_port = in_port;
  assign bus4.opecode = rom_op[bus4.addr];
  assign bus4.imm     = rom_imm[bus4.addr];

  td4_exec_core #(.CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus8));
  td4_exec_core #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [3:0] addr;
    logic [3:0] outp;
    logic       c;
    logic [7:0] ret;
  } vec_t;

  vec_t tbl[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_nops();
    for (int i = 0; i < 16; i++) begin
      rom_op[i]  = 4'b1000;
      rom_imm[i] = 4'h0;
    end
  endtask

  task automatic put(input int a, input logic [3:0] op, input logic [3:0] im);
    rom_op[a]  = op;
    rom_imm[a] = im;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    run_en = 1'b1;
    step   = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int idx;
    rst_n   = 1'b0;
    run_en  = 1'b1;
    step    = 1'b0;
    in_port = 4'h3;

    // Counter program
    load_nops();
    put(0,  4'b0110, 4'h0);  // IN B
    put(1,  4'b1001, 4'h0);  // OUT B
    put(2,  4'b0011, 4'hF);  // MOV A,15
    put(3,  4'b0000, 4'h1);  // ADD A,1
    put(4,  4'b1110, 4'h3);  // JNC 3
    put(5,  4'b0101, 4'h1);  // ADD B,1
    put(6,  4'b1110, 4'h1);  // JNC 1
    put(7,  4'b1011, 4'h0);  // OUT 0
    put(8,  4'b1000, 4'h0);  // NOP
    put(9,  4'b1011, 4'hF);  // OUT 15
    put(10, 4'b1111, 4'h7);  // JMP 7

    tbl[0]  = '{1,  4'd1,  4'h0, 1'b0, 8'd1};
    tbl[1]  = '{2,  4'd2,  4'h3, 1'b0, 8'd2};
    tbl[2]  = '{3,  4'd3,  4'h3, 1'b0, 8'd3};
    tbl[3]  = '{4,  4'd4,  4'h3, 1'b1, 8'd4};
    tbl[4]  = '{5,  4'd5,  4'h3, 1'b0, 8'd5};
    tbl[5]  = '{6,  4'd6,  4'h3, 1'b0, 8'd6};
    tbl[6]  = '{7,  4'd1,  4'h3, 1'b0, 8'd7};
    tbl[7]  = '{8,  4'd2,  4'h4, 1'b0, 8'd8};
    tbl[8]  = '{74, 4'd2,  4'hF, 1'b0, 8'd74};
    tbl[9]  = '{75, 4'd3,  4'hF, 1'b0, 8'd75};
    tbl[10] = '{76, 4'd4,  4'hF, 1'b1, 8'd76};
    tbl[11] = '{77, 4'd5,  4'hF, 1'b0, 8'd77};
    tbl[12] = '{78, 4'd6,  4'hF, 1'b1, 8'd78};
    tbl[13] = '{79, 4'd7,  4'hF, 1'b0, 8'd79};
    tbl[14] = '{80, 4'd8,  4'h0, 1'b0, 8'd80};
    tbl[15] = '{81, 4'd9,  4'h0, 1'b0, 8'd81};
    tbl[16] = '{82, 4'd10, 4'hF, 1'b0, 8'd82};
    tbl[17] = '{83, 4'd7,  4'hF, 1'b0, 8'd83};

    // Reset held two clocks with run_en high
    do_reset();
    chk("rst_addr",    32'(bus8.addr),     32'd0);
    chk("rst_out",     32'(bus8.out_port), 32'd0);
    chk("rst_carry",   32'(bus8.carry),    32'd0);
    chk("rst_retired", 32'(bus8.retired),  32'd0);

    rst_n = 1'b1;
    idx = 0;
    for (int e = 1; e <= 84; e++) begin
      tick();
      if (idx < 18 && tbl[idx].edge_n == e) begin
        chk($sformatf("cnt_addr@%0d", e),  32'(bus8.addr),    32'(tbl[idx].addr));
        chk($sformatf("cnt_out@%0d", e),   32'(bus8.out_port), 32'(tbl[idx].outp));
        chk($sformatf("cnt_carry@%0d", e), 32'(bus8.carry),   32'(tbl[idx].c));
        chk($sformatf("cnt_ret@%0d", e),   32'(bus8.retired), 32'(tbl[idx].ret));
        idx++;
      end
      if (e >= 2 && e <= 79)
        chk($sformatf("cnt_led@%0d", e), 32'(bus8.out_port), 32'(3 + (e - 2) / 6));
      if (e == 84) begin
        chk("loop_out84",  32'(bus8.out_port), 32'h0);
        chk("loop_addr84", 32'(bus8.addr),     32'd8);
        chk("ret4_84",     32'(bus4.retired),  32'd4);
      end
    end

    // Carry clear after a carrying ADD, then JNC taken
    load_nops();
    put(0, 4'b0011, 4'hF);   // MOV A,15
    put(1, 4'b0000, 4'h1);   // ADD A,1
    put(2, 4'b0011, 4'h5);   // MOV A,5
    put(3, 4'b1110, 4'h9);   // JNC 9
    do_reset();
    rst_n = 1'b1;
    tick();
    tick();
    chk("cc_add_carry", 32'(bus8.carry), 32'd1);
    tick();
    chk("cc_mov_carry", 32'(bus8.carry), 32'd0);
    tick();
    chk("cc_jnc_taken", 32'(bus8.addr),  32'd9);

    // Single-step
    load_nops();
    do_reset();
    run_en = 1'b0;
    rst_n  = 1'b1;
    tick();
    chk("ss_idle_ret", 32'(bus8.retired), 32'd0);
    step = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("ss_hold_ret",  32'(bus8.retired), 32'd1);
    chk("ss_hold_addr", 32'(bus8.addr),    32'd1);
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    chk("ss_second_ret",  32'(bus8.retired), 32'd2);
    chk("ss_second_addr", 32'(bus8.addr),    32'd2);
    // Step edge while running executes only once
    run_en = 1'b1;
    step   = 1'b0;
    tick();
    step = 1'b1;
    tick();
    chk("run_step_ret", 32'(bus8.retired), 32'd4);
    run_en = 1'b0;
    tick();
    tick();
    chk("freeze_ret",  32'(bus8.retired), 32'd4);
    chk("freeze_addr", 32'(bus8.addr),    32'd4);
    // Reset on a step-edge cycle retires nothing
    step = 1'b0;
    tick();
    step  = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("rst_step_ret",  32'(bus8.retired), 32'd0);
    chk("rst_step_addr", 32'(bus8.addr),    32'd0);
    step = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_step_after", 32'(bus8.retired), 32'd0);

    // PC wrap and counter wrap on NOPs
    load_nops();
    do_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk($sformatf("wrap_addr@%0d", k), 32'(bus8.addr), 32'(k % 16));
      if (k == 16) chk("ret4_wrap16", 32'(bus4.retired), 32'd0);
    end
    chk("wrap_ret",   32'(bus8.retired),  32'd17);
    chk("wrap_ret4",  32'(bus4.retired),  32'd1);
    chk("wrap_out",   32'(bus8.out_port), 32'd0);
    chk("wrap_carry", 32'(bus8.carry),    32'd0);
    run_en = 1'b0;
    tick();
    tick();
    tick();
    chk("stop_addr", 32'(bus8.addr),    32'd1);
    chk("stop_ret",  32'(bus8.retired), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
